ho_frame_loader: RTL

//  Upstream input stage of the obfuscated-AES core (HO_main): packs a 32-bit word stream into
//  128-bit key/data frames, drives Kin/Din and single-cycle Krdy/Drdy pulses, tracks Kvld/Dvld.

---
 rtl/ho_pkg.sv | 22 ++
 rtl/ho_word_packer.sv | 50 +++++
 rtl/ho_frame_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ho_pkg.sv
// Shared definitions for the HO_main frame loader.
// State encoding, error codes and frame geometry.
package ho_pkg;

    localparam int FRAME_W = 128;
    localparam int WORDS   = 4;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE       = 3'd0;
    localparam state_t S_COLLECT    = 3'd1;
    localparam state_t S_ISSUE_KEY  = 3'd2;
    localparam state_t S_WAIT_KEY   = 3'd3;
    localparam state_t S_ISSUE_DATA = 3'd4;
    localparam state_t S_WAIT_DATA  = 3'd5;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_TAG   = 2'b01;
    localparam logic [1:0] ERR_NOKEY = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

endpackage

// File: rtl/ho_word_packer.sv
// Packs 32-bit stream words MSB-first into a 128-bit frame.
// Tracks the word count and checks every word against the frame tag.
import ho_pkg::*;

module ho_word_packer #(
    parameter int WORD_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_W-1:0]  word,
    input  logic               tag,
    input  logic               take,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_tag,
    output logic               tag_err,
    output logic               last
);

    localparam int SH_W = FRAME_W - WORD_W;

    logic [SH_W-1:0] shreg;
    logic [1:0]      cnt;
    logic            ftag;

    // A mismatching word is only possible once a frame tag is latched
    assign tag_err   = take && (cnt != 2'd0) && (tag != ftag);
    assign last      = take && (cnt == 2'(WORDS - 1)) && !tag_err;
    assign frame     = {shreg, word};
    assign frame_tag = ftag;

    // Shift register, word counter and frame tag; a bad word drops the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= 2'd0;
            ftag  <= 1'b0;
        end else if (take) begin
            if (tag_err) begin
                cnt <= 2'd0;
            end else begin
                shreg <= frame[SH_W-1:0];
                cnt   <= cnt + 2'd1;
                if (cnt == 2'd0) begin
                    ftag <= tag;
                end
            end
        end
    end

endmodule

// File: rtl/ho_frame_loader.sv
// Input stage of the obfuscated AES core: frames the word stream,
// sequences key before data, hands frames to the core and reports errors.
import ho_pkg::*;

module ho_frame_loader #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WORD_W-1:0]  s_data,
    input  logic               s_tag,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [FRAME_W-1:0] Kin,
    output logic [FRAME_W-1:0] Din,
    output logic               Krdy,
    output logic               Drdy,
    input  logic               Kvld,
    input  logic               Dvld,
    input  logic               BSY,
    output logic               key_loaded,
    output logic               err,
    output logic [1:0]         err_code
);

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    state_t state;
    state_t nstate;

    logic               take;
    logic [FRAME_W-1:0] frame;
    logic               frame_tag;
    logic               tag_err;
    logic               last;

    logic [7:0] tmo_cnt;
    logic [7:0] tmo_next;
    logic       tmo_hit;

    logic       rdy_d;
    logic       krdy_d;
    logic       drdy_d;
    logic       err_d;
    logic [1:0] code_d;
    logic       load_k;
    logic       load_d;
    logic       kl_set;
    logic       kl_clr;
    logic       tmo_clr;
    logic       tmo_inc;

    assign take = s_valid & s_ready;

    ho_word_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk       (CLK),
        .rst       (RST),
        .word      (s_data),
        .tag       (s_tag),
        .take      (take),
        .frame     (frame),
        .frame_tag (frame_tag),
        .tag_err   (tag_err),
        .last      (last)
    );

    // Wait counter saturates so it can never wrap back below the limit
    assign tmo_next = (tmo_cnt == 8'hFF) ? tmo_cnt : tmo_cnt + 8'd1;
    assign tmo_hit  = (tmo_next == TMO_LIMIT);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= nstate;
        end
    end

    // Next-state logic
    always_comb begin
        nstate = state;
        case (state)
            S_IDLE: begin
                if (take) begin
                    nstate = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (tag_err) begin
                    nstate = S_IDLE;
                end else if (last) begin
                    if (!frame_tag) begin
                        nstate = S_ISSUE_KEY;
                    end else if (key_loaded) begin
                        nstate = S_ISSUE_DATA;
                    end else begin
                        nstate = S_IDLE;
                    end
                end
            end
            S_ISSUE_KEY: begin
                if (!BSY) begin
                    nstate = S_WAIT_KEY;
                end
            end
            S_ISSUE_DATA: begin
                if (!BSY) begin
                    nstate = S_WAIT_DATA;
                end
            end
            S_WAIT_KEY: begin
                if (Kvld || tmo_hit) begin
                    nstate = S_IDLE;
                end
            end
            S_WAIT_DATA: begin
                if (Dvld || tmo_hit) begin
                    nstate = S_IDLE;
                end
            end
            default: nstate = S_IDLE;
        endcase
    end

    // Output decode: next values for the registered outputs
    always_comb begin
        rdy_d   = (nstate == S_IDLE) || (nstate == S_COLLECT);
        krdy_d  = 1'b0;
        drdy_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = ERR_NONE;
        load_k  = 1'b0;
        load_d  = 1'b0;
        kl_set  = 1'b0;
        kl_clr  = 1'b0;
        tmo_clr = 1'b0;
        tmo_inc = 1'b0;
        case (state)
            S_COLLECT: begin
                if (tag_err) begin
                    err_d  = 1'b1;
                    code_d = ERR_TAG;
                end else if (last) begin
                    if (!frame_tag) begin
                        load_k = 1'b1;
                    end else if (key_loaded) begin
                        load_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_NOKEY;
                    end
                end
            end
            S_ISSUE_KEY: begin
                if (!BSY) begin
                    krdy_d  = 1'b1;
                    kl_clr  = 1'b1;
                    tmo_clr = 1'b1;
                end
            end
            S_ISSUE_DATA: begin
                if (!BSY) begin
                    drdy_d  = 1'b1;
                    tmo_clr = 1'b1;
                end
            end
            S_WAIT_KEY: begin
                if (Kvld) begin
                    kl_set = 1'b1;
                end else begin
                    tmo_inc = 1'b1;
                    if (tmo_hit) begin
                        err_d  = 1'b1;
                        code_d = ERR_TMO;
                        kl_clr = 1'b1;
                    end
                end
            end
            S_WAIT_DATA: begin
                if (!Dvld) begin
                    tmo_inc = 1'b1;
                    if (tmo_hit) begin
                        err_d  = 1'b1;
                        code_d = ERR_TMO;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s_ready    <= 1'b0;
            Kin        <= '0;
            Din        <= '0;
            Krdy       <= 1'b0;
            Drdy       <= 1'b0;
            key_loaded <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            tmo_cnt    <= 8'd0;
        end else begin
            s_ready <= rdy_d;
            Krdy    <= krdy_d;
            Drdy    <= drdy_d;
            err     <= err_d;
            if (err_d) begin
                err_code <= code_d;
            end
            if (load_k) begin
                Kin <= frame;
            end
            if (load_d) begin
                Din <= frame;
            end
            if (kl_set) begin
                key_loaded <= 1'b1;
            end else if (kl_clr) begin
                key_loaded <= 1'b0;
            end
            if (tmo_clr) begin
                tmo_cnt <= 8'd0;
            end else if (tmo_inc) begin
                tmo_cnt <= tmo_next;
            end
        end
    end

endmodule
